// File: rtl/fsm_array_if.sv
// Channel condition inputs, global controls and per-channel status outputs of fsm_array.
// The master side drives conditions and controls; the slave side is the FSM array.
interface fsm_array_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [CH-1:0]    a;
  logic [CH-1:0]    b;
  logic [CH-1:0]    c;
  logic             cnt_clr;
  logic [CH-1:0]    k;
  logic [CH-1:0]    m;
  logic [CH-1:0]    l;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    to_pulse;
  logic [CNT_W-1:0] l_cnt;

  modport master (
    output en, a, b, c, cnt_clr,
    input  k, m, l, busy, to_pulse, l_cnt
  );

  modport slave (
    input  en, a, b, c, cnt_clr,
    output k, m, l, busy, to_pulse, l_cnt
  );
endinterface

// File: rtl/fsm_array.sv
// Array of CH independent channel FSMs with per-channel dwell timeout and a shared
// saturating counter of L-state entries.
module fsm_array #(
  parameter int unsigned CH      = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  fsm_array_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StK    = 3'b001,
    StM    = 3'b010,
    StL    = 3'b100,
    StMl   = 3'b110
  } state_e;

  // Dwell never needs to exceed TIMEOUT-1, the value at which the timeout fires.
  localparam int unsigned DW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DwellLast = DW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam int unsigned SW = CNT_W + 5;
  localparam logic [SW-1:0] CntMax = {5'b0, {CNT_W{1'b1}}};

  state_e           state_q [CH];
  state_e           state_d [CH];
  logic [DW-1:0]    dwell_q [CH];
  logic [DW-1:0]    dwell_d [CH];
  logic [CH-1:0]    pulse_d;
  logic [CH-1:0]    l_enter;
  logic [CH-1:0]    k_q, m_q, l_q, busy_q, to_pulse_q;
  logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
  logic [SW-1:0]    cnt_sum;

  always_comb begin
    pulse_d = '0;
    l_enter = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      dwell_d[i] = dwell_q[i];
      if (bus_io.en) begin
        if (!bus_io.a[i] && !bus_io.b[i] && !bus_io.c[i]) begin
          state_d[i] = StIdle;
        end else if (state_q[i] == StIdle && bus_io.b[i]) begin
          state_d[i] = bus_io.a[i] ? StMl : StK;
        end else if (state_q[i] == StMl && bus_io.b[i] && bus_io.c[i]) begin
          state_d[i] = bus_io.a[i] ? StL : StM;
        end else if ((TIMEOUT != 0) && state_q[i] != StIdle && dwell_q[i] == DwellLast) begin
          state_d[i] = StIdle;
          pulse_d[i] = 1'b1;
        end
        if (state_d[i] != state_q[i] || state_d[i] == StIdle) begin
          dwell_d[i] = '0;
        end else begin
          dwell_d[i] = dwell_q[i] + DW'(1);
        end
        l_enter[i] = (state_d[i] == StL) && (state_q[i] != StL);
      end
    end
  end

  always_comb begin
    cnt_sum = {5'b0, l_cnt_q};
    for (int i = 0; i < CH; i++) begin
      cnt_sum = cnt_sum + SW'(l_enter[i]);
    end
    if (bus_io.cnt_clr) begin
      l_cnt_d = '0;
    end else if (cnt_sum > CntMax) begin
      l_cnt_d = {CNT_W{1'b1}};
    end else begin
      l_cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  // Decoded flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= StIdle;
        dwell_q[i] <= '0;
      end
      k_q        <= '0;
      m_q        <= '0;
      l_q        <= '0;
      busy_q     <= '0;
      to_pulse_q <= '0;
      l_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        dwell_q[i] <= dwell_d[i];
        k_q[i]     <= (state_d[i] == StK);
        m_q[i]     <= (state_d[i] == StM);
        l_q[i]     <= (state_d[i] == StL);
        busy_q[i]  <= (state_d[i] != StIdle);
      end
      to_pulse_q <= pulse_d;
      l_cnt_q    <= l_cnt_d;
    end
  end

  assign bus_io.k        = k_q;
  assign bus_io.m        = m_q;
  assign bus_io.l        = l_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.to_pulse = to_pulse_q;
  assign bus_io.l_cnt    = l_cnt_q;

endmodule

// File: tb/tb_fsm_array.sv
// Directed bench for fsm_array with CH=2, TIMEOUT=4, CNT_W=4.
module tb_fsm_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  fsm_array_if #(.CH(2), .CNT_W(4)) intf ();

  fsm_array #(.CH(2), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (intf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] av, input logic [1:0] bv, input logic [1:0] cv);
    intf.a = av;
    intf.b = bv;
    intf.c = cv;
  endtask

  // Masked channels go IDLE->ML->L then back to IDLE via clear.
  task automatic round(input logic [1:0] mask, input logic [3:0] exp_cnt, input string tag);
    drive(mask, mask, 2'b00);
    step();
    drive(mask, mask, mask);
    step();
    check({tag, "_l"}, 16'(intf.l), 16'(mask));
    check({tag, "_cnt"}, 16'(intf.l_cnt), 16'(exp_cnt));
    drive(2'b00, 2'b00, 2'b00);
    step();
  endtask

  initial begin
    intf.en = 1'b0;
    intf.cnt_clr = 1'b0;
    drive(2'b00, 2'b00, 2'b00);
    #3;
    check("rst_k", 16'(intf.k), 16'h0);
    check("rst_busy", 16'(intf.busy), 16'h0);
    check("rst_pulse", 16'(intf.to_pulse), 16'h0);
    check("rst_cnt", 16'(intf.l_cnt), 16'h0);
    #4 rst_n = 1'b1;
    step();
    intf.en = 1'b1;

    // ch0 IDLE -> ML -> L
    drive(2'b01, 2'b01, 2'b00);
    step();
    check("ml_busy", 16'(intf.busy), 16'h1);
    check("ml_flags", 16'({intf.k, intf.m, intf.l}), 16'h0);
    drive(2'b01, 2'b01, 2'b01);
    step();
    check("l_flag", 16'(intf.l), 16'h1);
    check("l_cnt1", 16'(intf.l_cnt), 16'h1);

    // Clear out of L
    drive(2'b00, 2'b00, 2'b00);
    step();
    check("clr_busy", 16'(intf.busy), 16'h0);
    check("clr_l", 16'(intf.l), 16'h0);
    check("clr_pulse", 16'(intf.to_pulse), 16'h0);

    // ch1 into K, timeout after 4 enabled cycles
    drive(2'b00, 2'b10, 2'b00);
    step();
    check("k_enter", 16'(intf.k), 16'h2);
    step();
    step();
    step();
    check("k_dwell3", 16'(intf.k), 16'h2);
    check("k_nopulse", 16'(intf.to_pulse), 16'h0);
    step();
    check("to_k", 16'(intf.k), 16'h0);
    check("to_pulse", 16'(intf.to_pulse), 16'h2);
    check("to_busy", 16'(intf.busy), 16'h0);
    step();
    check("to_pulse_once", 16'(intf.to_pulse), 16'h0);
    check("k_reenter", 16'(intf.k), 16'h2);
    drive(2'b00, 2'b00, 2'b00);
    step();

    // Freeze with en=0 partway through the dwell
    drive(2'b00, 2'b10, 2'b00);
    step();
    step();
    step();
    intf.en = 1'b0;
    drive(2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) step();
    check("frz_k", 16'(intf.k), 16'h2);
    check("frz_pulse", 16'(intf.to_pulse), 16'h0);
    intf.en = 1'b1;
    drive(2'b00, 2'b10, 2'b00);
    step();
    check("frz_k_after", 16'(intf.k), 16'h2);
    step();
    check("frz_to_k", 16'(intf.k), 16'h0);
    check("frz_to_pulse", 16'(intf.to_pulse), 16'h2);
    drive(2'b00, 2'b00, 2'b00);
    step();
    check("frz_pulse_end", 16'(intf.to_pulse), 16'h0);

    // Both channels enter L together, count saturates at 15
    round(2'b11, 4'd3, "dual1");
    round(2'b11, 4'd5, "dual2");
    round(2'b11, 4'd7, "dual3");
    round(2'b11, 4'd9, "dual4");
    round(2'b11, 4'd11, "dual5");
    round(2'b11, 4'd13, "dual6");
    round(2'b11, 4'd15, "dual7");
    round(2'b11, 4'd15, "sat1");
    round(2'b01, 4'd15, "sat2");

    // cnt_clr wins over simultaneous L entries
    drive(2'b11, 2'b11, 2'b00);
    step();
    drive(2'b11, 2'b11, 2'b11);
    intf.cnt_clr = 1'b1;
    step();
    intf.cnt_clr = 1'b0;
    check("cclr_l", 16'(intf.l), 16'h3);
    check("cclr_cnt", 16'(intf.l_cnt), 16'h0);
    step();
    check("stay_l_nocount", 16'(intf.l_cnt), 16'h0);
    drive(2'b00, 2'b00, 2'b00);
    step();

    round(2'b11, 4'd2, "re1");
    round(2'b11, 4'd4, "re2");
    drive(2'b01, 2'b01, 2'b00);
    step();
    drive(2'b01, 2'b01, 2'b01);
    step();
    check("pre_rst_l", 16'(intf.l), 16'h1);
    check("pre_rst_cnt", 16'(intf.l_cnt), 16'h5);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_l", 16'(intf.l), 16'h0);
    check("arst_busy", 16'(intf.busy), 16'h0);
    check("arst_cnt", 16'(intf.l_cnt), 16'h0);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_busy", 16'(intf.busy), 16'h1);
    check("post_rst_l", 16'(intf.l), 16'h0);
    check("post_rst_cnt", 16'(intf.l_cnt), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
